// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the execute stage: ALU ops, mul/div ops and the
// iterative multiply/divide FSM states.
package muldiv_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_NOR  = 4'h5,
        ALU_SLT  = 4'h6,
        ALU_SLTU = 4'h7,
        ALU_SLL  = 4'h8,
        ALU_SRL  = 4'h9,
        ALU_SRA  = 4'hA,
        ALU_LUI  = 4'hB
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_SIGN = 2'b10
    } md_state_e;

    typedef struct packed {
        logic is_div;
        logic is_signed;
    } md_ctl_t;

    function automatic md_ctl_t md_decode(input logic [1:0] op);
        md_ctl_t c;
        c.is_div    = (op == MD_DIVU) || (op == MD_DIV);
        c.is_signed = (op == MD_MULT) || (op == MD_DIV);
        return c;
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Final sign correction of the unsigned {hi, lo} result:
// full 2*WIDTH negate for multiply, independent halves for divide.
module muldiv_signfix #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_val,
    input  logic               i_div,
    input  logic               i_neg_q,
    input  logic               i_neg_r,
    output logic [2*WIDTH-1:0] o_val
);

    logic [2*WIDTH-1:0] w_full;
    logic [WIDTH-1:0]   w_q;
    logic [WIDTH-1:0]   w_r;

    assign w_full = -i_val;
    assign w_q    = -i_val[WIDTH-1:0];
    assign w_r    = -i_val[2*WIDTH-1:WIDTH];

    always_comb begin
        o_val = i_val;
        if (!i_div) begin
            if (i_neg_q) begin
                o_val = w_full;
            end
        end else begin
            if (i_neg_q) begin
                o_val[WIDTH-1:0] = w_q;
            end
            if (i_neg_r) begin
                o_val[2*WIDTH-1:WIDTH] = w_r;
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring
// shift-subtract step per cycle, then a single sign-fixup cycle.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_e          r_state;
    md_state_e          w_next;
    logic [CW-1:0]      r_cnt;
    md_ctl_t            r_ctl;
    logic               r_neg_a;
    logic               r_neg_b;
    logic               r_dz;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_prod;
    logic [WIDTH:0]     r_rem;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_dbz;

    md_ctl_t            w_ctl;
    logic               w_dz_in;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_ma;
    logic [WIDTH-1:0]   w_mb;
    logic               w_load;
    logic               w_step;
    logic               w_finish;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH+1:0]   w_shift;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_raw;
    logic [2*WIDTH-1:0] w_fix;
    logic               w_neg_q;
    logic               w_neg_r;

    assign w_ctl   = md_decode(op);
    assign w_dz_in = w_ctl.is_div && (b == '0);
    assign w_a_neg = w_ctl.is_signed && a[WIDTH-1];
    assign w_b_neg = w_ctl.is_signed && b[WIDTH-1];
    assign w_ma    = w_a_neg ? -a : a;
    assign w_mb    = w_b_neg ? -b : b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start && !flush) begin
                    w_load = 1'b1;
                    w_next = w_dz_in ? ST_SIGN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    w_next = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        w_next = ST_SIGN;
                    end
                end
            end
            ST_SIGN: begin
                w_next   = ST_IDLE;
                w_finish = !flush;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Multiply: upper half accumulates, multiplier shifts out of the low end.
    assign w_mul_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]}
                     + (r_prod[0] ? {1'b0, r_opnd} : '0);

    // Divide: remainder shifts in the next dividend bit from the low half.
    assign w_shift = {r_rem, r_prod[WIDTH-1]};
    assign w_ge    = (w_shift >= {2'b00, r_opnd});
    assign w_diff  = w_shift[WIDTH:0] - {1'b0, r_opnd};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt   <= '0;
            r_ctl   <= '0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_dz    <= 1'b0;
            r_opnd  <= '0;
            r_prod  <= '0;
            r_rem   <= '0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_dbz   <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_cnt   <= '0;
                r_ctl   <= w_ctl;
                r_neg_a <= w_a_neg;
                r_neg_b <= w_b_neg;
                r_dz    <= w_dz_in;
                r_opnd  <= w_ctl.is_div ? w_mb : w_ma;
                if (w_dz_in) begin
                    r_rem  <= {1'b0, a};
                    r_prod <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                end else begin
                    r_rem  <= '0;
                    r_prod <= {{WIDTH{1'b0}}, w_ctl.is_div ? w_ma : w_mb};
                end
            end
            if (w_step) begin
                r_cnt <= r_cnt + CW'(1);
                if (r_ctl.is_div) begin
                    r_rem  <= w_ge ? w_diff : w_shift[WIDTH:0];
                    r_prod <= {r_prod[2*WIDTH-1:WIDTH],
                               r_prod[WIDTH-2:0], w_ge};
                end else begin
                    r_prod <= {w_mul_sum, r_prod[WIDTH-1:1]};
                end
            end
            if (w_finish) begin
                r_hi  <= w_fix[2*WIDTH-1:WIDTH];
                r_lo  <= w_fix[WIDTH-1:0];
                r_dbz <= r_dz;
            end
        end
    end

    // Divide-by-zero results are architectural as loaded: no sign fixup.
    assign w_raw   = r_ctl.is_div ? {r_rem[WIDTH-1:0], r_prod[WIDTH-1:0]}
                                  : r_prod;
    assign w_neg_q = !r_dz && (r_neg_a ^ r_neg_b);
    assign w_neg_r = !r_dz && r_neg_a;

    muldiv_signfix #(
        .WIDTH(WIDTH)
    ) u_signfix (
        .i_val  (w_raw),
        .i_div  (r_ctl.is_div),
        .i_neg_q(w_neg_q),
        .i_neg_r(w_neg_r),
        .o_val  (w_fix)
    );

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign hi          = r_hi;
    assign lo          = r_lo;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model with
// cycle-count timing, checked every cycle, plus literal expectations.
module tb_muldiv_unit;

    localparam int W = 32;

    logic          clock;
    logic          reset;
    logic          start;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          flush;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;
    logic          div_by_zero;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .div_by_zero(div_by_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Returns {div_by_zero, hi, lo} from plain arithmetic.
    function automatic logic [64:0] ref_op(input logic [1:0] o,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
        logic [63:0] u;
        longint      sx64;
        longint      sy64;
        longint      p;
        int          sx;
        int          sy;
        logic [31:0] q;
        logic [31:0] r;
        case (o)
            2'b00: begin
                u = {32'b0, x} * {32'b0, y};
                return {1'b0, u};
            end
            2'b01: begin
                sx64 = $signed(x);
                sy64 = $signed(y);
                p = sx64 * sy64;
                return {1'b0, p};
            end
            2'b10: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, x % y, x / y};
            end
            default: begin
                if (y == 0) return {1'b1, x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF)
                    return {1'b0, 32'h0, 32'h8000_0000};
                sx = $signed(x);
                sy = $signed(y);
                q = sx / sy;
                r = sx % sy;
                return {1'b0, r, q};
            end
        endcase
    endfunction

    int          m_left = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic        m_dbz = 1'b0;
    logic [64:0] m_pend = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_hi   = '0;
            m_lo   = '0;
            m_dbz  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                if (flush) begin
                    m_left = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_done = 1'b1;
                        {m_dbz, m_hi, m_lo} = m_pend;
                    end
                end
            end else if (start && !flush) begin
                m_pend = ref_op(op, a, b);
                m_left = (op[1] && b == 0) ? 1 : W + 1;
            end
        end
    end

    always @(negedge clock) begin
        chk("cyc busy", busy, (m_left > 0) ? 1 : 0);
        chk("cyc done", done, m_done);
        chk("cyc hi", hi, m_hi);
        chk("cyc lo", lo, m_lo);
        chk("cyc dbz", div_by_zero, m_dbz);
    end

    task automatic do_op(input string nm, input logic [1:0] o,
                         input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el,
                         input logic ed, input int lat,
                         input int fl_at, input int st_at);
        int n;
        int bc;
        bit got;
        @(posedge clock); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clock); #1;
        start = 1'b0;
        op = 2'($urandom);
        a = $urandom;
        b = $urandom;
        bc = busy ? 1 : 0;
        n = 0;
        got = 1'b0;
        while (!got && n < 60) begin
            @(posedge clock); n++; #1;
            flush = (fl_at > 0 && n == fl_at - 1);
            if (st_at > 0 && n == st_at - 1) begin
                start = 1'b1; op = 2'b10; a = 32'd1; b = 32'd0;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (done) got = 1'b1;
            if (busy) bc++;
        end
        flush = 1'b0;
        start = 1'b0;
        if (fl_at > 0) begin
            chk({nm, " no-done"}, got, 0);
            chk({nm, " idle"}, busy, 0);
        end else begin
            chk({nm, " done"}, got, 1);
            chk({nm, " latency"}, n, lat);
            chk({nm, " busy-cycles"}, bc, lat);
        end
        chk({nm, " hi"}, hi, eh);
        chk({nm, " lo"}, lo, el);
        chk({nm, " dbz"}, div_by_zero, ed);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op = 2'b00;
        a = '0;
        b = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst hi", hi, 0);
        chk("rst lo", lo, 0);
        chk("rst dbz", div_by_zero, 0);
        @(negedge clock);
        reset = 1'b1;

        do_op("multu max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, 0, 0);
        do_op("mult -3*7", 2'b01, 32'hFFFF_FFFD, 32'd7,
              32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 33, 0, 0);
        do_op("div -7/2", 2'b11, 32'hFFFF_FFF9, 32'd2,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, 0, 0);
        do_op("divu 100/0", 2'b10, 32'd100, 32'd0,
              32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1, 0, 0);
        do_op("divu 100/7", 2'b10, 32'd100, 32'd7,
              32'd2, 32'd14, 1'b0, 33, 0, 0);
        do_op("div min/-1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
              32'h0, 32'h8000_0000, 1'b0, 33, 0, 0);
        do_op("div 7/-2", 2'b11, 32'd7, 32'hFFFF_FFFE,
              32'd1, 32'hFFFF_FFFD, 1'b0, 33, 0, 0);
        do_op("mult -1*-1", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'h0, 32'h1, 1'b0, 33, 0, 0);
        do_op("div -7/0", 2'b11, 32'hFFFF_FFF9, 32'd0,
              32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 1, 0, 0);
        do_op("multu flush", 2'b00, 32'd5, 32'd6,
              32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0, 10, 0);
        do_op("multu restart", 2'b00, 32'd5, 32'd6,
              32'h0, 32'd30, 1'b0, 33, 0, 5);
        do_op("mult min*min", 2'b01, 32'h8000_0000, 32'h8000_0000,
              32'h4000_0000, 32'h0, 1'b0, 33, 0, 0);
        do_op("divu max/1", 2'b10, 32'hFFFF_FFFF, 32'd1,
              32'h0, 32'hFFFF_FFFF, 1'b0, 33, 0, 0);

        @(posedge clock); #1;
        start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd2; b = 32'd3;
        @(posedge clock); #1;
        start = 1'b0; flush = 1'b0;
        chk("idle flush busy", busy, 0);
        repeat (3) @(posedge clock);
        #1;
        chk("idle flush no-start", busy, 0);

        @(posedge clock); #1;
        start = 1'b1; op = 2'b00; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (8) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        chk("async rst busy", busy, 0);
        chk("async rst done", done, 0);
        chk("async rst hi", hi, 0);
        chk("async rst lo", lo, 0);
        chk("async rst dbz", div_by_zero, 0);
        @(negedge clock);
        reset = 1'b1;

        do_op("multu 2*3", 2'b00, 32'd2, 32'd3,
              32'h0, 32'd6, 1'b0, 33, 0, 0);

        repeat (2) @(posedge clock);
        @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, is the operand width; legal values are even and >= 4.
REQ-002 Port clock, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1 bit: reset, asynchronous, active-low.
REQ-004 Port start, input, 1 bit: request a new operation; sampled only in IDLE.
REQ-005 Port op, input, 2 bits: operation select; 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 Port a, input, WIDTH bits: multiplicand or dividend.
REQ-007 Port b, input, WIDTH bits: multiplier or divisor.
REQ-008 Port flush, input, 1 bit: abort the operation in flight (EX-stage flush).
REQ-009 Port busy, output, 1 bit: operation in progress; the pipeline stalls MFHI/MFLO and any new mul/div on it.
REQ-010 Port done, output, 1 bit: one-cycle pulse marking that hi/lo have just been updated.
REQ-011 Port hi, output, WIDTH bits: product upper half, or remainder.
REQ-012 Port lo, output, WIDTH bits: product lower half, or quotient.
REQ-013 Port div_by_zero, output, 1 bit: the last completed divide had b == 0; valid with done and held until the next completion.

Function
REQ-014 The FSM has three states: IDLE, RUN and SIGN.
REQ-015 IDLE with start=1 and flush=0: latch a, b and op at edge E0. Divides with b==0 go to SIGN; all other operations go to RUN with step counter = 0.
REQ-016 RUN performs one step per edge: shift-add for multiply, restoring shift-subtract for divide. Signed ops use operand magnitudes. After WIDTH steps (edge E_WIDTH) the FSM moves to SIGN.
REQ-017 At the edge that leaves SIGN, the FSM applies the sign fixup, registers hi, lo and div_by_zero, sets done=1 for exactly one cycle, and returns to IDLE.
REQ-018 Latency: done is high in the cycle after edge E_(WIDTH+1); for divide-by-zero, in the cycle after E1.
REQ-019 busy=1 in RUN and SIGN; busy=0 in IDLE, including the cycle in which done is high.
REQ-020 MULT fixup: negate the 2*WIDTH-bit product when a[WIDTH-1] XOR b[WIDTH-1].
REQ-021 DIV fixup: negate the quotient when the operand signs differ; the remainder takes the sign of the dividend.
REQ-022 DIV with most-negative / -1: lo = most-negative value (wraps), hi = 0.
REQ-023 Any divide with b == 0: lo = all-ones, hi = a, div_by_zero = 1. For all other completions div_by_zero = 0.
REQ-024 start while busy is ignored and does not queue.
REQ-025 flush=1 in RUN or SIGN: return to IDLE at the next edge, with no done pulse and hi/lo/div_by_zero unchanged.
REQ-026 flush=1 with start=1 in IDLE: flush wins and no operation starts.
REQ-027 hi and lo hold their values until the next completion; inputs a, b and op may change freely after E0.
REQ-028 All internal arithmetic uses unsigned WIDTH+1-bit remainder and 2*WIDTH-bit product registers; no overflow indication.

Reset
REQ-029 reset=0 forces IDLE immediately, including mid-operation.
REQ-030 During reset: busy = 0, done = 0, hi = 0, lo = 0, div_by_zero = 0, step counter = 0.
REQ-031 After reset release, the first start is accepted at the first rising edge.

Structure
REQ-032 The op encodings (MULTU, MULT, DIVU, DIV) and the FSM state encodings reside in a shared package with the ALU/control encodings.
REQ-033 The step counter is $clog2(WIDTH)+1 bits wide.
REQ-034 The magnitude/negate fixup is a sub-module, muldiv_signfix, instantiated once for the {hi, lo} pair.

Verification
REQ-035 WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; done in the cycle after E33; busy high for exactly 33 cycles.
REQ-036 MULT a=-3 b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-037 DIVU a=100 b=0 -> done in the cycle after E1, lo=0xFFFFFFFF, hi=0x00000064, div_by_zero=1; a following DIVU 100/7 -> lo=14, hi=2, div_by_zero=0.
REQ-038 DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 MULTU 5*6 with flush at cycle 10 -> no done, hi/lo keep their prior values; a restart after the flush completes normally with lo=30. A start pulse while busy is ignored.
REQ-040 reset=0 asserted mid-RUN -> busy, done, hi and lo read 0 asynchronously; after release, MULTU 2*3 -> lo=6 with the full latency.
